s27_bist_ctrl: RTL and testbench

Built-in self-test sequencer for the s27 sequential core. On `start` it holds the core in reset for a programmable number of cycles, then drives a pseudo-random stimulus stream onto G0..G3 from a 4-bit LFSR. It compacts the G17 response into a 16-bit MISR and reports the signature, with an optional golden-signature pass/fail. It sits beside the s27 instance in the optimizer example and shares its clock net.

---
 rtl/s27_bist_pkg.sv | 24 ++
 rtl/s27_bist_misr.sv | 34 +++
 rtl/s27_bist_ctrl.sv | 135 +++++++++++++
 tb/tb_s27_bist_ctrl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/s27_bist_pkg.sv
// s27_bist_pkg: shared types and constants for the s27 BIST sequencer.
//   bist_state_e : sequencer states (IDLE, DUT_RST, RUN, DONE)
//   LFSR_W/MISR_W: stimulus and signature widths
//   MISR_POLY    : x^16+x^12+x^5+1 feedback taps
//   lfsr_next()  : one step of the x^4+x^3+1 Fibonacci LFSR
package s27_bist_pkg;

  localparam int unsigned LFSR_W = 4;
  localparam int unsigned MISR_W = 16;
  localparam logic [MISR_W-1:0] MISR_POLY = 16'h1021;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DUT_RST = 2'd1,
    RUN     = 2'd2,
    DONE    = 2'd3
  } bist_state_e;

  // Period-15 sequence; the all-zero state is a lockup and is kept out by the seed.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
    return {q[2:0], q[3] ^ q[2]};
  endfunction

endpackage

// File: rtl/s27_bist_misr.sv
// s27_bist_misr: 16-bit serial-input MISR (x^16+x^12+x^5+1).
//   i_clk   : clock, rising edge
//   i_rst   : synchronous active-high reset (clears signature)
//   i_clear : synchronous clear
//   i_en    : shift in i_din this edge
//   i_din   : serial response bit
//   o_sig   : current signature
//   o_next  : signature after the next enabled shift (lets a caller compare
//             the final value on the same edge it is captured)
module s27_bist_misr
  import s27_bist_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_en,
  input  logic              i_din,
  output logic [MISR_W-1:0] o_sig,
  output logic [MISR_W-1:0] o_next
);

  logic [MISR_W-1:0] r_sig;
  logic              w_fb;

  assign w_fb   = r_sig[MISR_W-1] ^ i_din;
  assign o_next = {r_sig[MISR_W-2:0], 1'b0} ^ (w_fb ? MISR_POLY : '0);
  assign o_sig  = r_sig;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) r_sig <= '0;
    else if (i_en)        r_sig <= o_next;
  end

endmodule

// File: rtl/s27_bist_ctrl.sv
// s27_bist_ctrl: BIST sequencer for the s27 core. Holds the core in reset,
// streams LFSR patterns onto G0..G3 and compacts G17 into a MISR.
//   clk_net, reset_net : clock (rising) and synchronous active-high reset
//   start, abort       : begin test (IDLE/DONE only) / cancel running test
//   dut_g17            : s27 response bit
//   dut_reset, dut_g   : s27 reset and {G3,G2,G1,G0} stimulus (registered)
//   busy, done, pass   : status; pass valid while done
//   signature          : MISR contents
//   pattern_idx        : patterns applied in the current test
// Optional: define S27_BIST_COMPARE_EN to build the GOLDEN_SIG comparator;
// otherwise pass is tied 0.
module s27_bist_ctrl
  import s27_bist_pkg::*;
#(
  parameter int unsigned        PATTERN_COUNT = 255,
  parameter int unsigned        RST_CYCLES    = 2,
  parameter logic [LFSR_W-1:0]  LFSR_SEED     = 4'b1001,
  parameter logic [MISR_W-1:0]  GOLDEN_SIG    = 16'h0000
) (
  input  logic              clk_net,
  input  logic              reset_net,
  input  logic              start,
  input  logic              abort,
  input  logic              dut_g17,
  output logic              dut_reset,
  output logic [LFSR_W-1:0] dut_g,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [MISR_W-1:0] signature,
  output logic [15:0]       pattern_idx
);

  localparam logic [LFSR_W-1:0] SEED     = (LFSR_SEED == '0) ? 4'b0001 : LFSR_SEED;
  localparam logic [3:0]        RST_LOAD = 4'(RST_CYCLES - 1);
  localparam logic [15:0]       LAST_IDX = 16'(PATTERN_COUNT - 1);

  bist_state_e       r_state, w_state_nxt;
  logic [3:0]        r_rst_cnt, w_rst_cnt_nxt;
  logic [LFSR_W-1:0] r_lfsr, w_lfsr_nxt;
  logic [LFSR_W-1:0] r_dut_g, w_dut_g_nxt;
  logic [15:0]       r_idx, w_idx_nxt;
  logic              r_pass, w_pass_nxt;
  logic              w_misr_clr, w_misr_en;
`ifdef S27_BIST_COMPARE_EN
  logic [MISR_W-1:0] w_misr_nxt;
`endif

  always_ff @(posedge clk_net) begin
    if (reset_net) begin
      r_state   <= IDLE;
      r_rst_cnt <= '0;
      r_lfsr    <= '0;
      r_dut_g   <= '0;
      r_idx     <= '0;
      r_pass    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rst_cnt <= w_rst_cnt_nxt;
      r_lfsr    <= w_lfsr_nxt;
      r_dut_g   <= w_dut_g_nxt;
      r_idx     <= w_idx_nxt;
      r_pass    <= w_pass_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_rst_cnt_nxt = r_rst_cnt;
    w_lfsr_nxt    = r_lfsr;
    w_idx_nxt     = r_idx;
    w_pass_nxt    = r_pass;
    w_misr_clr    = 1'b0;
    w_misr_en     = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        // start beats a simultaneous abort here; abort alone is ignored
        if (start) begin
          w_state_nxt   = DUT_RST;
          w_rst_cnt_nxt = RST_LOAD;
          w_lfsr_nxt    = SEED;
          w_idx_nxt     = '0;
          w_pass_nxt    = 1'b0;
          w_misr_clr    = 1'b1;
        end
      end
      DUT_RST: begin
        if (abort)                w_state_nxt   = IDLE;
        else if (r_rst_cnt == '0) w_state_nxt   = RUN;
        else                      w_rst_cnt_nxt = r_rst_cnt - 4'd1;
      end
      RUN: begin
        if (abort) begin
          w_state_nxt = IDLE;
        end else begin
          // G17 seen this cycle belongs to the pattern retiring at this edge
          w_misr_en  = 1'b1;
          w_lfsr_nxt = lfsr_next(r_lfsr);
          w_idx_nxt  = r_idx + 16'd1;
          if (r_idx == LAST_IDX) begin
            w_state_nxt = DONE;
`ifdef S27_BIST_COMPARE_EN
            w_pass_nxt  = (w_misr_nxt == GOLDEN_SIG);
`endif
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    // Stimulus is registered: preload the pattern the next RUN cycle will use
    w_dut_g_nxt = (w_state_nxt == RUN) ? w_lfsr_nxt : '0;
  end

  s27_bist_misr u_misr (
    .i_clk   (clk_net),
    .i_rst   (reset_net),
    .i_clear (w_misr_clr),
    .i_en    (w_misr_en),
    .i_din   (dut_g17),
    .o_sig   (signature),
`ifdef S27_BIST_COMPARE_EN
    .o_next  (w_misr_nxt)
`else
    .o_next  ()
`endif
  );

  assign dut_reset   = (r_state == DUT_RST);
  assign busy        = (r_state == DUT_RST) || (r_state == RUN);
  assign done        = (r_state == DONE);
  assign dut_g       = r_dut_g;
  assign pattern_idx = r_idx;
  assign pass        = r_pass;

endmodule

// File: tb/tb_s27_bist_ctrl.sv
module tb_s27_bist_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort, g17;
  logic        dut_reset, busy, done, pass;
  logic [3:0]  dut_g;
  logic [15:0] sig, idx;

  logic        start1, g17_1;
  logic        dut_reset1, busy1, done1, pass1;
  logic [3:0]  dut_g1;
  logic [15:0] sig1, idx1;

  int n_chk  = 0;
  int n_fail = 0;

`ifdef S27_BIST_COMPARE_EN
  localparam logic ZERO_PASS = 1'b1;
`else
  localparam logic ZERO_PASS = 1'b0;
`endif

  always #5 clk = ~clk;

  s27_bist_ctrl #(.PATTERN_COUNT(4), .RST_CYCLES(2), .LFSR_SEED(4'b1001),
                  .GOLDEN_SIG(16'h0000)) u_dut (
    .clk_net(clk), .reset_net(rst), .start(start), .abort(abort),
    .dut_g17(g17), .dut_reset(dut_reset), .dut_g(dut_g), .busy(busy),
    .done(done), .pass(pass), .signature(sig), .pattern_idx(idx));

  s27_bist_ctrl #(.PATTERN_COUNT(1), .RST_CYCLES(2), .LFSR_SEED(4'b1001),
                  .GOLDEN_SIG(16'h0000)) u_dut1 (
    .clk_net(clk), .reset_net(rst), .start(start1), .abort(1'b0),
    .dut_g17(g17_1), .dut_reset(dut_reset1), .dut_g(dut_g1), .busy(busy1),
    .done(done1), .pass(pass1), .signature(sig1), .pattern_idx(idx1));

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Advance one edge; sample 1ns later, well away from the next edge.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk_quiet(input string tag);
    check({tag, ".busy"},  busy, 0);
    check({tag, ".done"},  done, 0);
    check({tag, ".dutrst"}, dut_reset, 0);
    check({tag, ".dutg"},  dut_g, 0);
  endtask

  // Full 4-pattern run from start pulse; g17 held at g17v for every RUN cycle.
  task automatic run_full(input string tag, input logic sa, input logic g17v,
                          input logic [15:0] exp_sig, input logic exp_pass);
    logic [3:0] pat [4];
    pat[0] = 4'b1001; pat[1] = 4'b0011; pat[2] = 4'b0110; pat[3] = 4'b1101;
    start = 1'b1; abort = sa; g17 = g17v;
    tick();                                   // edge 0
    start = 1'b0; abort = 1'b0;
    check({tag, ".busy0"}, busy, 1);
    check({tag, ".done0"}, done, 0);
    check({tag, ".pass0"}, pass, 0);
    check({tag, ".rst0"},  dut_reset, 1);
    check({tag, ".g0"},    dut_g, 0);
    tick();                                   // edge 1
    check({tag, ".rst1"},  dut_reset, 1);
    for (int i = 0; i < 4; i++) begin
      tick();                                 // edges 2..5
      check($sformatf("%s.pat%0d", tag, i), dut_g, pat[i]);
      check($sformatf("%s.rstr%0d", tag, i), dut_reset, 0);
      check($sformatf("%s.dn%0d", tag, i), done, 0);
    end
    tick();                                   // edge 6
    check({tag, ".done"}, done, 1);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".idx"},  idx, 16'd4);
    check({tag, ".sig"},  sig, exp_sig);
    check({tag, ".pass"}, pass, exp_pass);
    check({tag, ".gend"}, dut_g, 0);
    tick();                                   // done holds
    check({tag, ".hold"}, done, 1);
    check({tag, ".sigh"}, sig, exp_sig);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; g17 = 1'b0; start1 = 1'b0; g17_1 = 1'b0;
    tick(); tick();
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.pass", pass, 0);
    check("rst.dutrst", dut_reset, 0);
    check("rst.dutg", dut_g, 0);
    check("rst.sig", sig, 0);
    check("rst.idx", idx, 0);
    rst = 1'b0;
    tick();
    // abort alone in IDLE does nothing
    abort = 1'b1; tick(); abort = 1'b0;
    chk_quiet("idle_abort");

    // zero response, latency and pattern order
    run_full("zero", 1'b0, 1'b0, 16'h0000, ZERO_PASS);
    // start+abort together in DONE: start wins; all-ones response
    run_full("ones", 1'b1, 1'b1, 16'hF1EF, 1'b0);

    // single-one response on the PATTERN_COUNT=1 instance
    start1 = 1'b1; tick(); start1 = 1'b0;
    tick(); tick();                           // now in RUN
    check("one.g", dut_g1, 4'b1001);
    g17_1 = 1'b1; tick(); g17_1 = 1'b0;
    check("one.done", done1, 1);
    check("one.sig", sig1, 16'h1021);
    check("one.idx", idx1, 16'd1);
    check("one.pass", pass1, 0);

    // abort in the 2nd RUN cycle, with G17=1 in the first
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); g17 = 1'b1;               // 1st RUN cycle
    tick(); g17 = 1'b0;                       // 2nd RUN cycle
    check("ab.busy_pre", busy, 1);
    // start while busy must be ignored (no restart, no queuing)
    start = 1'b1; abort = 1'b1;
    tick(); start = 1'b0; abort = 1'b0;
    chk_quiet("ab");
    check("ab.sig", sig, 16'h1021);
    check("ab.idx", idx, 16'd1);
    tick();
    chk_quiet("ab2");
    run_full("after_ab", 1'b0, 1'b0, 16'h0000, ZERO_PASS);

    // reset mid-RUN
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); g17 = 1'b1; tick();
    check("mr.busy_pre", busy, 1);
    rst = 1'b1; tick();
    chk_quiet("mr");
    check("mr.sig", sig, 0);
    check("mr.idx", idx, 0);
    check("mr.pass", pass, 0);
    rst = 1'b0; g17 = 1'b0;
    tick();
    chk_quiet("mr2");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
